// File: rtl/load_store_unit_pkg.sv
// Shared definitions for the load/store unit: size codes, RAM write-enable
// encodings, FSM states and the default address limit.
package load_store_unit_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  localparam logic [2:0] WE_NONE = 3'b000;
  localparam logic [2:0] WE_WORD = 3'b001;
  localparam logic [2:0] WE_HALF = 3'b010;
  localparam logic [2:0] WE_BYTE = 3'b100;

  localparam logic [31:0] ADDR_LIMIT_DEFAULT = 32'd2048;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_RESP    = 2'd3
  } lsu_state_t;

  function automatic logic [2:0] size_to_we(input logic [1:0] size);
    case (size)
      SZ_BYTE: size_to_we = WE_BYTE;
      SZ_HALF: size_to_we = WE_HALF;
      SZ_WORD: size_to_we = WE_WORD;
      default: size_to_we = WE_NONE;
    endcase
  endfunction

endpackage

// File: rtl/load_store_unit_formatter.sv
// Combinational load-data formatter: picks byte/half/word from right-aligned
// RAM data and sign- or zero-extends it to 32 bits.
module load_formatter
  import load_store_unit_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  size,
  input  logic        uns,
  output logic [31:0] data
);

  always_comb begin
    data = rdata;
    case (size)
      SZ_BYTE: data = {{24{~uns & rdata[7]}}, rdata[7:0]};
      SZ_HALF: data = {{16{~uns & rdata[15]}}, rdata[15:0]};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit between execute stage and a registered-read data RAM.
// Optional macro LSU_MISALIGN_TRAP_EN turns misaligned half/word accesses into errors.
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter logic [31:0] ADDR_LIMIT = ADDR_LIMIT_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] mem_addr,
  output logic [2:0]  mem_we,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  lsu_state_t  state_reg, state_next;
  logic        write_reg;
  logic        unsigned_reg;
  logic [1:0]  size_reg;
  logic [31:0] addr_reg;
  logic [31:0] wdata_reg;
  logic [31:0] resp_rdata_reg;
  logic        resp_err_reg;
  logic [31:0] fmt_data;
  logic        accept;
  logic        misaligned;
  logic        req_error;

  assign req_ready  = (state_reg == ST_IDLE);
  assign resp_valid = (state_reg == ST_RESP);
  assign accept     = req_valid & req_ready;

`ifdef LSU_MISALIGN_TRAP_EN
  assign misaligned = ((req_size == SZ_HALF) && req_addr[0]) ||
                      ((req_size == SZ_WORD) && (req_addr[1:0] != 2'b00));
`else
  assign misaligned = 1'b0;
`endif

  assign req_error = (req_size == SZ_RSVD) || (req_addr >= ADDR_LIMIT) || misaligned;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= ST_IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:    if (accept) state_next = req_error ? ST_RESP : ST_ISSUE;
      ST_ISSUE:   state_next = write_reg ? ST_RESP : ST_CAPTURE;
      ST_CAPTURE: state_next = ST_RESP;
      ST_RESP:    if (resp_ready) state_next = ST_IDLE;
      default:    state_next = ST_IDLE;
    endcase
  end

  // Write enable is decoded from state so an asynchronous reset kills it at once.
  assign mem_we     = ((state_reg == ST_ISSUE) && write_reg) ? size_to_we(size_reg) : WE_NONE;
  assign mem_addr   = addr_reg;
  assign mem_wdata  = wdata_reg;
  assign resp_rdata = resp_rdata_reg;
  assign resp_err   = resp_err_reg;

  load_formatter u_fmt (
    .rdata (mem_rdata),
    .size  (size_reg),
    .uns   (unsigned_reg),
    .data  (fmt_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      write_reg      <= 1'b0;
      unsigned_reg   <= 1'b0;
      size_reg       <= SZ_BYTE;
      addr_reg       <= '0;
      wdata_reg      <= '0;
      resp_rdata_reg <= '0;
      resp_err_reg   <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: if (accept) begin
          write_reg      <= req_write;
          unsigned_reg   <= req_unsigned;
          size_reg       <= req_size;
          resp_err_reg   <= req_error;
          resp_rdata_reg <= '0;
          // Rejected requests leave the RAM-facing address/data untouched.
          if (!req_error) begin
            addr_reg <= req_addr;
            if (req_write) wdata_reg <= req_wdata;
          end
        end
        ST_CAPTURE: resp_rdata_reg <= fmt_data;
        ST_RESP: if (resp_ready) begin
          resp_err_reg   <= 1'b0;
          resp_rdata_reg <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed self-checking bench for load_store_unit with a behavioural registered-read RAM.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_write, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_ready, resp_err;
  logic [31:0] resp_rdata, mem_addr, mem_wdata, mem_rdata;
  logic [2:0]  mem_we;

  int checks = 0;
  int errors = 0;
  int we_count = 0;
  logic [31:0] ram [0:511];

  always #5 clk = ~clk;

  load_store_unit dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err), .mem_addr(mem_addr),
    .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // RAM: word index addr[10:2], data right-aligned and shifted by byte offset.
  always @(posedge clk) begin
    logic [31:0] mask;
    logic [4:0]  sh;
    sh = {mem_addr[1:0], 3'b000};
    mask = (mem_we == 3'b001) ? 32'hFFFF_FFFF :
           (mem_we == 3'b010) ? 32'h0000_FFFF :
           (mem_we == 3'b100) ? 32'h0000_00FF : 32'h0;
    if (mem_we != 3'b000) begin
      we_count <= we_count + 1;
      ram[mem_addr[10:2]] <= (ram[mem_addr[10:2]] & ~(mask << sh)) | ((mem_wdata << sh) & (mask << sh));
    end
    mem_rdata <= ram[mem_addr[10:2]] >> sh;
  end

  task automatic do_req(input logic w, input logic [1:0] sz, input logic u,
                        input logic [31:0] a, input logic [31:0] wd,
                        output logic [31:0] rd, output logic er, output int lat,
                        output logic [2:0] we0);
    @(negedge clk);
    req_valid = 1'b1; req_write = w; req_size = sz; req_unsigned = u;
    req_addr = a; req_wdata = wd;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    we0 = mem_we;
    lat = 0;
    while (!resp_valid && lat < 20) begin
      @(posedge clk); @(negedge clk);
      lat++;
    end
    rd = resp_rdata; er = resp_err;
    resp_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    resp_ready = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready got %b exp 1", req_ready); end
    checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL reset_resp_valid got %b exp 0", resp_valid); end
    checks++; if (resp_err !== 1'b0) begin errors++; $display("FAIL reset_resp_err got %b exp 0", resp_err); end
    checks++; if (resp_rdata !== 32'h0) begin errors++; $display("FAIL reset_resp_rdata got %h exp 0", resp_rdata); end
    checks++; if (mem_addr !== 32'h0) begin errors++; $display("FAIL reset_mem_addr got %h exp 0", mem_addr); end
    checks++; if (mem_we !== 3'b000) begin errors++; $display("FAIL reset_mem_we got %b exp 000", mem_we); end
    checks++; if (mem_wdata !== 32'h0) begin errors++; $display("FAIL reset_mem_wdata got %h exp 0", mem_wdata); end
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    $display("reset released");
  endtask

  task automatic test_word();
    logic [31:0] rd; logic er; int lat; logic [2:0] we0; int wc;
    wc = we_count;
    do_req(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, rd, er, lat, we0);
    $display("store word @10 lat=%0d we=%b", lat, we0);
    checks++; if (we0 !== 3'b001) begin errors++; $display("FAIL st_word_we got %b exp 001", we0); end
    checks++; if (we_count - wc !== 1) begin errors++; $display("FAIL st_word_we_cycles got %0d exp 1", we_count - wc); end
    checks++; if (lat !== 1) begin errors++; $display("FAIL st_word_lat got %0d exp 1", lat); end
    checks++; if (rd !== 32'h0 || er !== 1'b0) begin errors++; $display("FAIL st_word_resp got %h/%b exp 0/0", rd, er); end
    do_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, rd, er, lat, we0);
    $display("load word @10 -> %h lat=%0d", rd, lat);
    checks++; if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL ld_word_data got %h exp deadbeef", rd); end
    checks++; if (lat !== 2) begin errors++; $display("FAIL ld_word_lat got %0d exp 2", lat); end
    checks++; if (we0 !== 3'b000) begin errors++; $display("FAIL ld_word_we got %b exp 000", we0); end
  endtask

  task automatic test_extend();
    logic [31:0] rd; logic er; int lat; logic [2:0] we0;
    logic [31:0] exp_v [0:6];
    logic [1:0]  szs   [0:6];
    logic        us    [0:6];
    logic [31:0] ads   [0:6];
    do_req(1'b1, 2'b10, 1'b0, 32'h20, 32'h000080F0, rd, er, lat, we0);
    exp_v = '{32'hFFFFFFF0, 32'h00000080, 32'hFFFF80F0, 32'h000080F0, 32'hFFFFFF80, 32'h00000000, 32'h000000F0};
    szs   = '{2'b00, 2'b00, 2'b01, 2'b01, 2'b00, 2'b01, 2'b00};
    us    = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    ads   = '{32'h20, 32'h21, 32'h20, 32'h20, 32'h21, 32'h22, 32'h20};
    for (int i = 0; i < 7; i++) begin
      do_req(1'b0, szs[i], us[i], ads[i], 32'h0, rd, er, lat, we0);
      $display("load sz=%b u=%b @%h -> %h", szs[i], us[i], ads[i], rd);
      checks++; if (rd !== exp_v[i]) begin errors++; $display("FAIL ld_ext_%0d got %h exp %h", i, rd, exp_v[i]); end
    end
    do_req(1'b1, 2'b00, 1'b0, 32'h23, 32'h000000AB, rd, er, lat, we0);
    checks++; if (we0 !== 3'b100) begin errors++; $display("FAIL st_byte_we got %b exp 100", we0); end
    do_req(1'b1, 2'b01, 1'b0, 32'h22, 32'hFFFF1234, rd, er, lat, we0);
    checks++; if (we0 !== 3'b010) begin errors++; $display("FAIL st_half_we got %b exp 010", we0); end
    do_req(1'b0, 2'b10, 1'b0, 32'h20, 32'h0, rd, er, lat, we0);
    $display("load word @20 after sub-word stores -> %h", rd);
    checks++; if (rd !== 32'h123480F0) begin errors++; $display("FAIL st_subword_merge got %h exp 123480f0", rd); end
  endtask

  task automatic test_error();
    logic [31:0] rd; logic er; int lat; logic [2:0] we0; int wc;
    wc = we_count;
    do_req(1'b0, 2'b10, 1'b0, 32'h800, 32'h0, rd, er, lat, we0);
    $display("load @800 err=%b lat=%0d", er, lat);
    checks++; if (er !== 1'b1 || rd !== 32'h0) begin errors++; $display("FAIL err_limit got %b/%h exp 1/0", er, rd); end
    checks++; if (lat !== 0) begin errors++; $display("FAIL err_limit_lat got %0d exp 0", lat); end
    do_req(1'b1, 2'b11, 1'b0, 32'h10, 32'h12345678, rd, er, lat, we0);
    $display("store size=11 err=%b", er);
    checks++; if (er !== 1'b1 || rd !== 32'h0) begin errors++; $display("FAIL err_rsvd got %b/%h exp 1/0", er, rd); end
    do_req(1'b1, 2'b10, 1'b0, 32'hFFFFFFF0, 32'h12345678, rd, er, lat, we0);
    checks++; if (er !== 1'b1) begin errors++; $display("FAIL err_high_store got %b exp 1", er); end
    checks++; if (we_count !== wc) begin errors++; $display("FAIL err_no_write got %0d exp %0d", we_count, wc); end
    do_req(1'b1, 2'b10, 1'b0, 32'h7FC, 32'hCAFEF00D, rd, er, lat, we0);
    do_req(1'b0, 2'b10, 1'b0, 32'h7FC, 32'h0, rd, er, lat, we0);
    $display("load @7fc -> %h err=%b", rd, er);
    checks++; if (er !== 1'b0 || rd !== 32'hCAFEF00D) begin errors++; $display("FAIL last_word got %b/%h exp 0/cafef00d", er, rd); end
    do_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, rd, er, lat, we0);
    checks++; if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL word_intact got %h exp deadbeef", rd); end
  endtask

  task automatic test_backpressure();
    int n;
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0; req_size = 2'b10; req_unsigned = 1'b0;
    req_addr = 32'h10;
    @(posedge clk); @(negedge clk);
    req_valid = 1'b0;
    n = 0;
    while (!resp_valid && n < 20) begin @(posedge clk); @(negedge clk); n++; end
    checks++; if (n !== 2) begin errors++; $display("FAIL bp_lat got %0d exp 2", n); end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (resp_valid !== 1'b1 || resp_rdata !== 32'hDEADBEEF || req_ready !== 1'b0) begin
        errors++; $display("FAIL bp_hold_%0d got v=%b d=%h r=%b exp 1/deadbeef/0", i, resp_valid, resp_rdata, req_ready);
      end
      @(posedge clk); @(negedge clk);
    end
    resp_ready = 1'b1;
    checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL bp_ready_at_handshake got %b exp 0", req_ready); end
    @(posedge clk); @(negedge clk);
    resp_ready = 1'b0;
    $display("backpressure released v=%b ready=%b", resp_valid, req_ready);
    checks++; if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin errors++; $display("FAIL bp_release got v=%b r=%b exp 0/1", resp_valid, req_ready); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd; logic er; int lat; logic [2:0] we0;
    do_req(1'b1, 2'b10, 1'b0, 32'h30, 32'h5555AAAA, rd, er, lat, we0);
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_size = 2'b10; req_addr = 32'h30; req_wdata = 32'h11111111;
    @(posedge clk); #2;
    req_valid = 1'b0;
    checks++; if (mem_we !== 3'b001) begin errors++; $display("FAIL rst_mid_issue_we got %b exp 001", mem_we); end
    rst_n = 1'b0;
    #1;
    $display("reset during store issue we=%b v=%b ready=%b", mem_we, resp_valid, req_ready);
    checks++; if (mem_we !== 3'b000) begin errors++; $display("FAIL rst_mid_we got %b exp 000", mem_we); end
    checks++; if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin errors++; $display("FAIL rst_mid_state got v=%b r=%b exp 0/1", resp_valid, req_ready); end
    @(posedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin errors++; $display("FAIL rst_mid_after got v=%b r=%b exp 0/1", resp_valid, req_ready); end
    do_req(1'b0, 2'b10, 1'b0, 32'h30, 32'h0, rd, er, lat, we0);
    checks++; if (rd !== 32'h5555AAAA) begin errors++; $display("FAIL rst_mid_mem got %h exp 5555aaaa", rd); end
  endtask

  task automatic test_misalign();
    logic [31:0] rd; logic er; int lat; logic [2:0] we0;
    do_req(1'b0, 2'b10, 1'b0, 32'h22, 32'h0, rd, er, lat, we0);
    $display("load word @22 -> %h err=%b lat=%0d", rd, er, lat);
`ifdef LSU_MISALIGN_TRAP_EN
    checks++; if (er !== 1'b1 || rd !== 32'h0 || lat !== 0) begin errors++; $display("FAIL misalign_trap got %b/%h/%0d exp 1/0/0", er, rd, lat); end
`else
    checks++; if (er !== 1'b0 || rd !== 32'h00001234 || lat !== 2) begin errors++; $display("FAIL misalign_pass got %b/%h/%0d exp 0/1234/2", er, rd, lat); end
`endif
  endtask

  initial begin
    for (int i = 0; i < 512; i++) ram[i] = 32'h0;
    rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00;
    req_unsigned = 1'b0; req_addr = 32'h0; req_wdata = 32'h0; resp_ready = 1'b0;
    test_reset();
    test_word();
    test_extend();
    test_error();
    test_backpressure();
    test_reset_mid();
    test_misalign();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

endmodule
